router_reg: RTL and testbench

- Datapath/register block of a 1x3 packet router.
- Latches the header byte and forwards header and payload bytes to the FIFO write port on `dout`.
- Buffers the one byte that arrives while the target FIFO is full, and replays it afterwards.
- Accumulates XOR parity over header and payload, compares it with the trailing parity byte, and flags mismatches.
- All control strobes come from the router FSM.

---
 rtl/router_reg.sv | 102 ++++++++++
 tb/tb_router_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg.sv
// Datapath/register block of a 1x3 packet router: header latch, FIFO write data,
// overflow byte buffer and running XOR parity check against the trailing parity byte.
module router_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic             fifo_full,
  input  logic             rst_int_reg,
  input  logic             detect_add,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             parity_done,
  output logic             low_pkt_valid,
  output logic             err,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] hdr;
  logic [WIDTH-1:0] full_byte;
  logic [WIDTH-1:0] int_par;
  logic [WIDTH-1:0] pkt_par;
  logic             par_capture;

  // Parity byte is taken either straight from the bus or on the replay after an overflow.
  assign par_capture = (ld_state && !fifo_full && !pkt_valid) ||
                       (laf_state && low_pkt_valid && !parity_done);

  // Address 3 does not exist, so such a header never replaces the stored one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      hdr <= '0;
    else if (detect_add && pkt_valid && data_in[1:0] != 2'b11)
      hdr <= data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      full_byte <= '0;
    else if (ld_state && fifo_full)
      full_byte <= data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      dout <= '0;
    else if (lfd_state)
      dout <= hdr;
    else if (ld_state && !fifo_full)
      dout <= data_in;
    else if (laf_state)
      dout <= full_byte;
  end

  // The parity byte arrives with pkt_valid low, so it never folds into int_par.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      int_par <= '0;
    else if (detect_add)
      int_par <= '0;
    else if (lfd_state)
      int_par <= int_par ^ hdr;
    else if (ld_state && pkt_valid && !full_state)
      int_par <= int_par ^ data_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_par     <= '0;
      parity_done <= 1'b0;
    end else if (detect_add) begin
      pkt_par     <= '0;
      parity_done <= 1'b0;
    end else if (par_capture) begin
      pkt_par     <= data_in;
      parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg)
      low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid <= 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      err <= 1'b0;
    else if (detect_add)
      err <= 1'b0;
    else if (parity_done)
      err <= (int_par != pkt_par);
  end

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed table, hand-written overflow and
// address corner cases, then random packets against a packet-level reference model.
module tb_router_reg;

  typedef enum logic [2:0] {K_IDLE, K_DECODE, K_LFD, K_LOAD, K_FULL, K_LAF, K_RSTINT} kind_t;

  typedef struct {
    kind_t      kind;
    logic       pv;
    logic [7:0] din;
    logic [7:0] dout;
    logic       pd;
    logic       low;
    logic       err;
  } vec_t;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic       fifo_full;
  logic       rst_int_reg;
  logic       detect_add;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic [7:0] dout;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: packet-level view, parity kept as the list of absorbed bytes.
  logic [7:0] m_hdr, m_full, m_dout, m_pkt_par;
  logic       m_pdone, m_low, m_err;
  logic [7:0] m_q[$];

  vec_t tbl[10];

  router_reg #(.WIDTH(8)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .data_in(data_in), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .err(err), .dout(dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] xor_q();
    logic [7:0] p = 8'h00;
    foreach (m_q[i]) p = p ^ m_q[i];
    return p;
  endfunction

  task automatic model_reset();
    m_hdr = 0; m_full = 0; m_dout = 0; m_pkt_par = 0;
    m_pdone = 0; m_low = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_step(input kind_t k, input logic pv, input logic ff, input logic [7:0] din);
    logic       old_pdone = m_pdone;
    logic [7:0] old_par   = xor_q();
    logic [7:0] old_pkt   = m_pkt_par;
    if (k == K_DECODE) begin
      if (pv && din[1:0] != 2'b11) m_hdr = din;
      m_q.delete();
      m_pkt_par = 0; m_pdone = 0; m_err = 0;
    end else begin
      if (old_pdone) m_err = (old_par != old_pkt);
      case (k)
        K_LFD: begin
          m_dout = m_hdr;
          m_q.push_back(m_hdr);
        end
        K_LOAD: begin
          if (!ff) begin
            m_dout = din;
            if (!pv) begin m_pkt_par = din; m_pdone = 1; end
          end else begin
            m_full = din;
          end
          if (pv) m_q.push_back(din);
          else    m_low = 1;
        end
        K_LAF: begin
          m_dout = m_full;
          if (m_low && !m_pdone) begin m_pkt_par = din; m_pdone = 1; end
        end
        K_RSTINT: m_low = 0;
        default: ;
      endcase
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check_val("dout", dout, m_dout);
    check_val("parity_done", {7'b0, parity_done}, {7'b0, m_pdone});
    check_val("low_pkt_valid", {7'b0, low_pkt_valid}, {7'b0, m_low});
    check_val("err", {7'b0, err}, {7'b0, m_err});
    check_val("hdr", dut.hdr, m_hdr);
    check_val("int_par", dut.int_par, xor_q());
    check_val("pkt_par", dut.pkt_par, m_pkt_par);
    check_val("full_byte", dut.full_byte, m_full);
  endtask

  // Drives one cycle of strobes, then advances the model past the same edge.
  task automatic apply_stimulus(input kind_t k, input logic pv, input logic ff, input logic [7:0] din);
    @(negedge clock);
    detect_add  = (k == K_DECODE);
    lfd_state   = (k == K_LFD);
    ld_state    = (k == K_LOAD);
    full_state  = (k == K_FULL);
    laf_state   = (k == K_LAF);
    rst_int_reg = (k == K_RSTINT);
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = din;
    @(posedge clock);
    #1;
    model_step(k, pv, ff, din);
  endtask

  task automatic step_check(input kind_t k, input logic pv, input logic ff, input logic [7:0] din);
    apply_stimulus(k, pv, ff, din);
    check_output();
  endtask

  task automatic send_packet(input bit corrupt);
    int         len  = $urandom_range(1, 20);
    logic [1:0] addr = 2'($urandom_range(0, 2));
    logic [7:0] par;
    logic       ff;
    step_check(K_DECODE, 1, 0, {6'(len), addr});
    step_check(K_LFD, 1, 0, 8'($urandom));
    for (int i = 0; i < len; i++) begin
      ff = ($urandom_range(0, 4) == 0);
      step_check(K_LOAD, 1, ff, 8'($urandom));
      if (ff) begin
        repeat ($urandom_range(1, 2)) step_check(K_FULL, 1, 1, 8'($urandom));
        step_check(K_LAF, 1, 0, 8'($urandom));
      end
    end
    par = corrupt ? (xor_q() ^ 8'h5A) : xor_q();
    ff  = ($urandom_range(0, 3) == 0);
    step_check(K_LOAD, 0, ff, par);
    if (ff) begin
      step_check(K_FULL, 0, 1, par);
      step_check(K_LAF, 0, 0, par);
    end
    step_check(K_IDLE, 0, 0, 8'h00);
    check_val("rand_err", {7'b0, err}, {7'b0, corrupt});
    step_check(K_IDLE, 0, 0, 8'h00);
    step_check(K_RSTINT, 0, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] q0;

    tbl[0] = '{K_DECODE, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{K_LFD,    1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{K_LOAD,   1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{K_LOAD,   1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{K_LOAD,   1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{K_LOAD,   1'b1, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{K_LOAD,   1'b0, 8'h1E, 8'h1E, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{K_IDLE,   1'b0, 8'h00, 8'h1E, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{K_RSTINT, 1'b0, 8'h00, 8'h1E, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{K_DECODE, 1'b1, 8'h11, 8'h1E, 1'b0, 1'b0, 1'b0};

    // Reset with all-ones data, checked between edges and after an edge.
    resetn = 0; pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
    ld_state = 0; laf_state = 0; full_state = 0; lfd_state = 0; data_in = 8'hFF;
    model_reset();
    #1;
    check_output();
    @(posedge clock); #1;
    check_output();
    @(negedge clock);
    resetn = 1;

    // Good packet from the table.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].kind, tbl[i].pv, 1'b0, tbl[i].din);
      check_val("tbl_dout", dout, tbl[i].dout);
      check_val("tbl_pdone", {7'b0, parity_done}, {7'b0, tbl[i].pd});
      check_val("tbl_low", {7'b0, low_pkt_valid}, {7'b0, tbl[i].low});
      check_val("tbl_err", {7'b0, err}, {7'b0, tbl[i].err});
      check_output();
    end

    // Corrupted packet with random payload.
    step_check(K_DECODE, 1, 0, 8'h11);
    step_check(K_LFD, 1, 0, 8'h00);
    repeat (4) step_check(K_LOAD, 1, 0, 8'($urandom));
    step_check(K_LOAD, 0, 0, ~xor_q());
    check_val("bad_pdone", {7'b0, parity_done}, 8'h01);
    check_val("bad_err_early", {7'b0, err}, 8'h00);
    step_check(K_IDLE, 0, 0, 8'h00);
    check_val("bad_err", {7'b0, err}, 8'h01);
    step_check(K_RSTINT, 0, 0, 8'h00);
    check_val("bad_err_hold", {7'b0, err}, 8'h01);
    step_check(K_DECODE, 1, 0, 8'h11);
    check_val("bad_err_clr", {7'b0, err}, 8'h00);

    // Overflow: byte 0xF0 arrives while the FIFO is full, then is replayed.
    step_check(K_DECODE, 1, 0, 8'h42);
    step_check(K_LFD, 1, 0, 8'h00);
    last = 8'h00;
    for (int i = 0; i < 15; i++) begin
      last = 8'($urandom);
      step_check(K_LOAD, 1, 0, last);
    end
    step_check(K_LOAD, 1, 1, 8'hF0);
    q0 = xor_q();
    repeat (3) step_check(K_FULL, 1, 1, 8'($urandom));
    check_val("ovf_full_byte", dut.full_byte, 8'hF0);
    check_val("ovf_dout_hold", dout, last);
    check_val("ovf_int_par", dut.int_par, q0);
    step_check(K_LAF, 1, 0, 8'($urandom));
    check_val("ovf_laf_dout", dout, 8'hF0);
    step_check(K_LOAD, 1, 0, 8'hF0);
    step_check(K_LOAD, 0, 0, xor_q());
    step_check(K_IDLE, 0, 0, 8'h00);
    check_val("ovf_pdone", {7'b0, parity_done}, 8'h01);
    check_val("ovf_err", {7'b0, err}, 8'h00);
    step_check(K_RSTINT, 0, 0, 8'h00);

    // Address 3 header is ignored; the old header is written instead.
    step_check(K_DECODE, 1, 0, 8'h13);
    check_val("inv_hdr", dut.hdr, 8'h42);
    step_check(K_LFD, 1, 0, 8'h00);
    check_val("inv_dout", dout, 8'h42);

    // Asynchronous reset mid-packet, observed before the next clock edge.
    step_check(K_LOAD, 1, 0, 8'hA5);
    @(negedge clock);
    resetn = 0;
    detect_add = 0; lfd_state = 0; ld_state = 0; full_state = 0; laf_state = 0; rst_int_reg = 0;
    #2;
    model_reset();
    check_output();
    check_val("arst_dout", dout, 8'h00);
    @(negedge clock);
    resetn = 1;

    // Random packets against the model.
    for (int p = 0; p < 40; p++) send_packet($urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
